// File: rtl/rv32_pkg.sv
// RV32 pipeline packet types shared by the memory stage, plus its access-size helpers.
package rv32_pkg;

    typedef struct packed {
        logic        read_enable;
        logic        write_enable;
        logic [31:0] addr;
        logic [31:0] data;
    } rv32_mem_packet_t;

    typedef struct packed {
        logic [2:0] load_type;
        logic [1:0] store_type;
    } rv32_ex_control_packet_t;

    typedef struct packed {
        logic        valid_opcode;
        logic        dont_forward;
        logic [4:0]  rs1_sel;
        logic [4:0]  rs2_sel;
        logic [4:0]  wb_addr;
        logic [31:0] wb_pc;
        logic [31:0] wb_data;
        logic        wb_enable;
    } rv32_ex2mem_wb_packet_t;

    typedef struct packed {
        logic        valid_opcode;
        logic        dont_forward;
        logic [4:0]  rs1_sel;
        logic [4:0]  rs2_sel;
        logic [4:0]  wb_addr;
        logic [31:0] wb_pc;
        logic [31:0] wb_data;
        logic        wb_enable;
    } rv32_mem2wb_packet_t;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} rv32_mem_state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} rv32_access_size_t;

    localparam logic [2:0] LD_B  = 3'd0;
    localparam logic [2:0] LD_H  = 3'd1;
    localparam logic [2:0] LD_W  = 3'd2;
    localparam logic [2:0] LD_BU = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;

    localparam logic [1:0] ST_B = 2'd0;
    localparam logic [1:0] ST_H = 2'd1;
    localparam logic [1:0] ST_W = 2'd2;

    function automatic rv32_access_size_t load_size(input logic [2:0] lt);
        rv32_access_size_t sz;
        sz = SZ_WORD;
        if (lt == LD_B || lt == LD_BU) sz = SZ_BYTE;
        if (lt == LD_H || lt == LD_HU) sz = SZ_HALF;
        return sz;
    endfunction

    function automatic rv32_access_size_t store_size(input logic [1:0] st);
        rv32_access_size_t sz;
        sz = SZ_WORD;
        if (st == ST_B) sz = SZ_BYTE;
        if (st == ST_H) sz = SZ_HALF;
        return sz;
    endfunction

    function automatic logic is_misaligned(input rv32_access_size_t sz, input logic [1:0] off);
        return ((sz == SZ_HALF) && off[0]) || ((sz == SZ_WORD) && (off != 2'b00));
    endfunction

    function automatic logic [3:0] byte_enable(input rv32_access_size_t sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate narrow store data across all lanes so the byte enables alone pick the target.
    function automatic logic [31:0] store_lanes(input rv32_access_size_t sz, input logic [31:0] d);
        logic [31:0] w;
        case (sz)
            SZ_BYTE: w = {4{d[7:0]}};
            SZ_HALF: w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // x0 is never written, whatever the upstream enable says.
    function automatic rv32_mem2wb_packet_t to_mem2wb(input rv32_ex2mem_wb_packet_t wb,
                                                      input logic [31:0] data,
                                                      input logic en);
        rv32_mem2wb_packet_t p;
        p.valid_opcode = wb.valid_opcode;
        p.dont_forward = wb.dont_forward;
        p.rs1_sel      = wb.rs1_sel;
        p.rs2_sel      = wb.rs2_sel;
        p.wb_addr      = wb.wb_addr;
        p.wb_pc        = wb.wb_pc;
        p.wb_data      = data;
        p.wb_enable    = en && (wb.wb_addr != 5'd0);
        return p;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load formatter: picks the addressed byte/half of a response word and sign/zero extends it.
// Purely combinational; no state, no backpressure.
module load_align
    import rv32_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  load_type,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[{offset, 3'b000} +: 8];
        lane_h = offset[1] ? rdata[31:16] : rdata[15:0];
        case (load_type)
            LD_B:    data = {{24{lane_b[7]}}, lane_b};
            LD_H:    data = {{16{lane_h[15]}}, lane_h};
            LD_BU:   data = {24'd0, lane_b};
            LD_HU:   data = {16'd0, lane_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// RV32 data-memory stage: non-mem ops retire in 1 cycle, loads in >=3, stores in >=2 (gnt-dependent).
// in_ready is high only in IDLE, so upstream stalls for the whole life of a bus transaction.
module memory_stage
    import rv32_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  rv32_mem_packet_t        mem_packet,
    input  rv32_ex_control_packet_t ex_control_packet,
    input  rv32_ex2mem_wb_packet_t  wb_packet,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [ADDR_WIDTH-1:0]   dmem_addr,
    output logic [3:0]              dmem_be,
    output logic [31:0]             dmem_wdata,
    input  logic                    dmem_gnt,
    input  logic                    dmem_rvalid,
    input  logic [31:0]             dmem_rdata,
    output logic                    out_valid,
    output rv32_mem2wb_packet_t     mem2wb_packet,
    output logic                    misalign_err,
    output logic                    timeout_err
);

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    rv32_mem_state_t        state_q, state_d;
    logic [15:0]            wait_cnt_q;
    logic                   req_we_q;
    logic [ADDR_WIDTH-1:0]  req_addr_q;
    logic [3:0]             req_be_q;
    logic [31:0]            req_wdata_q;
    logic [1:0]             lane_q;
    logic [2:0]             load_type_q;
    rv32_ex2mem_wb_packet_t wb_q;
    logic                   out_valid_q;
    rv32_mem2wb_packet_t    mem2wb_q;
    logic                   misalign_q;
    logic                   timeout_q;

    logic                   accept;
    logic                   is_store;
    logic                   is_mem;
    rv32_access_size_t      acc_size;
    logic                   acc_misaligned;
    logic                   start_req;
    logic                   wait_expired;
    logic [31:0]            load_data;

    assign accept         = in_valid && in_ready;
    assign is_store       = mem_packet.write_enable;
    assign is_mem         = mem_packet.read_enable || mem_packet.write_enable;
    assign acc_size       = is_store ? store_size(ex_control_packet.store_type)
                                     : load_size(ex_control_packet.load_type);
    assign acc_misaligned = is_misaligned(acc_size, mem_packet.addr[1:0]);
    assign start_req      = accept && is_mem && !acc_misaligned;
    assign wait_expired   = (state_q == WAIT) && !dmem_rvalid
                            && ((wait_cnt_q + 16'd1) == TIMEOUT_LIMIT);

    load_align u_load_align (
        .rdata     (dmem_rdata),
        .offset    (lane_q),
        .load_type (load_type_q),
        .data      (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_req) state_d = REQ;
            REQ:     if (dmem_gnt) state_d = req_we_q ? IDLE : WAIT;
            WAIT:    if (dmem_rvalid || wait_expired) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == IDLE) && !rst;
        dmem_req = (state_q == REQ);
    end

    // Request fields are captured once at accept and held until the bus grants them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q  <= '0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_be_q    <= '0;
            req_wdata_q <= '0;
            lane_q      <= '0;
            load_type_q <= '0;
            wb_q        <= '0;
            out_valid_q <= 1'b0;
            mem2wb_q    <= '0;
            misalign_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            misalign_q  <= 1'b0;
            timeout_q   <= 1'b0;

            if (start_req) begin
                req_we_q    <= is_store;
                req_addr_q  <= {mem_packet.addr[ADDR_WIDTH-1:2], 2'b00};
                req_be_q    <= byte_enable(acc_size, mem_packet.addr[1:0]);
                req_wdata_q <= is_store ? store_lanes(acc_size, mem_packet.data) : 32'd0;
                lane_q      <= mem_packet.addr[1:0];
                load_type_q <= ex_control_packet.load_type;
                wb_q        <= wb_packet;
            end

            if (accept && !is_mem) begin
                out_valid_q <= 1'b1;
                mem2wb_q    <= to_mem2wb(wb_packet, wb_packet.wb_data, wb_packet.wb_enable);
            end

            if (accept && is_mem && acc_misaligned) begin
                out_valid_q <= 1'b1;
                misalign_q  <= 1'b1;
                mem2wb_q    <= to_mem2wb(wb_packet, wb_packet.wb_data, 1'b0);
            end

            if ((state_q == REQ) && dmem_gnt) begin
                wait_cnt_q <= '0;
                if (req_we_q) begin
                    out_valid_q <= 1'b1;
                    mem2wb_q    <= to_mem2wb(wb_q, wb_q.wb_data, 1'b0);
                end
            end

            if (state_q == WAIT) begin
                if (dmem_rvalid) begin
                    out_valid_q <= 1'b1;
                    mem2wb_q    <= to_mem2wb(wb_q, load_data, wb_q.wb_enable);
                end else if (wait_expired) begin
                    out_valid_q <= 1'b1;
                    timeout_q   <= 1'b1;
                    mem2wb_q    <= to_mem2wb(wb_q, wb_q.wb_data, 1'b0);
                end else begin
                    wait_cnt_q <= wait_cnt_q + 16'd1;
                end
            end
        end
    end

    assign dmem_we       = req_we_q;
    assign dmem_addr     = req_addr_q;
    assign dmem_be       = req_be_q;
    assign dmem_wdata    = req_wdata_q;
    assign out_valid     = out_valid_q;
    assign mem2wb_packet = mem2wb_q;
    assign misalign_err  = misalign_q;
    assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed and randomized transactions against a byte-arithmetic reference model.
module tb_memory_stage;
    import rv32_pkg::*;

    localparam int TO = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    rv32_mem_packet_t        mem_packet;
    rv32_ex_control_packet_t ex_control_packet;
    rv32_ex2mem_wb_packet_t  wb_packet;
    logic                    dmem_req;
    logic                    dmem_we;
    logic [31:0]             dmem_addr;
    logic [3:0]              dmem_be;
    logic [31:0]             dmem_wdata;
    logic                    dmem_gnt;
    logic                    dmem_rvalid;
    logic [31:0]             dmem_rdata;
    logic                    out_valid;
    rv32_mem2wb_packet_t     mem2wb_packet;
    logic                    misalign_err;
    logic                    timeout_err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    memory_stage #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .mem_packet        (mem_packet),
        .ex_control_packet (ex_control_packet),
        .wb_packet         (wb_packet),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_be           (dmem_be),
        .dmem_wdata        (dmem_wdata),
        .dmem_gnt          (dmem_gnt),
        .dmem_rvalid       (dmem_rvalid),
        .dmem_rdata        (dmem_rdata),
        .out_valid         (out_valid),
        .mem2wb_packet     (mem2wb_packet),
        .misalign_err      (misalign_err),
        .timeout_err       (timeout_err)
    );

    localparam logic [31:0] DL_ADDR  [4] = '{32'h2002, 32'h2002, 32'h2002, 32'h3000};
    localparam logic [31:0] DL_RDATA [4] = '{32'h1280_FF00, 32'h1280_FF00, 32'h1280_FF00, 32'hDEAD_BEEF};
    localparam logic [31:0] DL_EXP   [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_1280, 32'hDEAD_BEEF};
    localparam int          DL_LT    [4] = '{0, 3, 4, 2};
    localparam int          DL_GD    [4] = '{0, 0, 0, 3};
    localparam int          DL_RD    [4] = '{1, 1, 1, 2};

    localparam logic [31:0] MA_ADDR [6] = '{32'h4001, 32'h4003, 32'h4002, 32'h4001, 32'h4003, 32'h4001};
    localparam int          MA_TYPE [6] = '{1, 4, 2, 1, 2, 2};
    localparam bit          MA_ST   [6] = '{0, 0, 0, 1, 1, 0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic rv32_ex2mem_wb_packet_t rand_wb();
        rv32_ex2mem_wb_packet_t w;
        w.valid_opcode = 1'($urandom);
        w.dont_forward = 1'($urandom);
        w.rs1_sel      = 5'($urandom);
        w.rs2_sel      = 5'($urandom);
        w.wb_addr      = 5'($urandom_range(1, 31));
        w.wb_pc        = $urandom;
        w.wb_data      = $urandom;
        w.wb_enable    = 1'b1;
        return w;
    endfunction

    function automatic int ld_bytes(int lt);
        if (lt == 0 || lt == 3) return 1;
        if (lt == 1 || lt == 4) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] ref_be(int nb, logic [31:0] a);
        if (nb == 4) return 4'hF;
        return 4'(((1 << nb) - 1) << a[1:0]);
    endfunction

    function automatic logic [31:0] ref_wdata(int nb, logic [31:0] d);
        if (nb == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (nb == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] w, logic [31:0] a, int lt);
        int sh;
        logic [31:0] b, h;
        sh = 8 * int'(a[1:0]);
        b  = (w >> sh) & 32'hFF;
        h  = (w >> sh) & 32'hFFFF;
        case (lt)
            0:       return (b >= 32'd128)   ? b - 32'd256   : b;
            1:       return (h >= 32'd32768) ? h - 32'd65536 : h;
            3:       return b;
            4:       return h;
            default: return w;
        endcase
    endfunction

    function automatic rv32_mem2wb_packet_t expect_pkt(rv32_ex2mem_wb_packet_t w, logic [31:0] d, logic en);
        rv32_mem2wb_packet_t p;
        p.valid_opcode = w.valid_opcode;
        p.dont_forward = w.dont_forward;
        p.rs1_sel      = w.rs1_sel;
        p.rs2_sel      = w.rs2_sel;
        p.wb_addr      = w.wb_addr;
        p.wb_pc        = w.wb_pc;
        p.wb_data      = d;
        p.wb_enable    = en && (w.wb_addr != 5'd0);
        return p;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++;
        if ({in_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, out_valid,
             mem2wb_packet, misalign_err, timeout_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got req=%b we=%b addr=%h be=%h wd=%h ov=%b pkt=%h rdy=%b", dmem_req,
                     dmem_we, dmem_addr, dmem_be, dmem_wdata, out_valid, mem2wb_packet, in_ready);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_alu();
        rv32_mem2wb_packet_t last;
        for (int i = 0; i < 10; i++) begin
            rv32_ex2mem_wb_packet_t wb;
            rv32_mem2wb_packet_t exp;
            wb = rand_wb();
            if (i == 0) begin wb.wb_data = 32'd5; wb.wb_addr = 5'd3; wb.wb_enable = 1'b1; end
            if (i == 1) begin wb.wb_addr = 5'd0; wb.wb_enable = 1'b1; end
            if (i > 1) wb.wb_enable = 1'($urandom);
            mem_packet = '{read_enable: 1'b0, write_enable: 1'b0, addr: $urandom, data: $urandom};
            ex_control_packet = 5'($urandom);
            wb_packet = wb;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            exp = expect_pkt(wb, wb.wb_data, wb.wb_enable);
            n_cmp++;
            if ({out_valid, dmem_req, in_ready, mem2wb_packet} !== {1'b1, 1'b0, 1'b1, exp}) begin
                n_fail++;
                $display("FAIL alu_%0d got ov=%b req=%b rdy=%b pkt=%h want 1 0 1 %h", i, out_valid, dmem_req,
                         in_ready, mem2wb_packet, exp);
            end
            last = exp;
        end
        step();
        n_cmp++;
        if ({out_valid, mem2wb_packet} !== {1'b0, last}) begin
            n_fail++;
            $display("FAIL alu_hold got ov=%b pkt=%h want 0 %h", out_valid, mem2wb_packet, last);
        end
    endtask

    task automatic test_store();
        for (int i = 0; i < 10; i++) begin
            rv32_ex2mem_wb_packet_t wb;
            int st, nb, gd;
            logic [31:0] a, d, ea, ew;
            logic [3:0] eb;
            st = (i == 0) ? 0 : $urandom_range(0, 2);
            nb = 1 << st;
            a  = (i == 0) ? 32'h1003 : ($urandom & ~32'(nb - 1));
            d  = (i == 0) ? 32'h0000_00AB : $urandom;
            gd = (i == 0) ? 0 : $urandom_range(0, 3);
            wb = rand_wb();
            ea = a & 32'hFFFF_FFFC;
            eb = ref_be(nb, a);
            ew = ref_wdata(nb, d);
            mem_packet = '{read_enable: 1'b0, write_enable: 1'b1, addr: a, data: d};
            ex_control_packet = '{load_type: 3'($urandom), store_type: 2'(st)};
            wb_packet = wb;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            mem_packet.addr = $urandom;
            mem_packet.data = $urandom;
            for (int c = 0; c <= gd; c++) begin
                n_cmp++;
                if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, in_ready, out_valid}
                    !== {1'b1, 1'b1, ea, eb, ew, 1'b0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL store_%0d_req got req=%b we=%b addr=%h be=%b wd=%h rdy=%b want 1 1 %h %b %h 0",
                             i, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, in_ready, ea, eb, ew);
                end
                dmem_gnt = (c == gd);
                step();
            end
            dmem_gnt = 1'b0;
            n_cmp++;
            if ({out_valid, mem2wb_packet.wb_enable, mem2wb_packet.wb_pc, dmem_req, in_ready}
                !== {1'b1, 1'b0, wb.wb_pc, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL store_%0d_done got ov=%b wbe=%b pc=%h req=%b rdy=%b want 1 0 %h 0 1", i, out_valid,
                         mem2wb_packet.wb_enable, mem2wb_packet.wb_pc, dmem_req, in_ready, wb.wb_pc);
            end
        end
    endtask

    task automatic test_load();
        for (int i = 0; i < 14; i++) begin
            rv32_ex2mem_wb_packet_t wb;
            rv32_mem2wb_packet_t exp;
            int lt, nb, gd, rd;
            logic [31:0] a, w, ea, ed;
            logic [3:0] eb;
            if (i < 4) begin
                lt = DL_LT[i]; a = DL_ADDR[i]; w = DL_RDATA[i]; gd = DL_GD[i]; rd = DL_RD[i]; ed = DL_EXP[i];
            end else begin
                lt = $urandom_range(0, 4);
                a  = $urandom & ~32'(ld_bytes(lt) - 1);
                w  = $urandom;
                gd = $urandom_range(0, 3);
                rd = $urandom_range(1, 3);
                ed = ref_load(w, a, lt);
            end
            nb = ld_bytes(lt);
            ea = a & 32'hFFFF_FFFC;
            eb = ref_be(nb, a);
            wb = rand_wb();
            if (i == 5) wb.wb_addr = 5'd0;
            mem_packet = '{read_enable: 1'b1, write_enable: 1'b0, addr: a, data: $urandom};
            ex_control_packet = '{load_type: 3'(lt), store_type: 2'($urandom)};
            wb_packet = wb;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            mem_packet.addr = $urandom;
            ex_control_packet.load_type = 3'($urandom_range(0, 4));
            for (int c = 0; c <= gd; c++) begin
                n_cmp++;
                if ({dmem_req, dmem_we, dmem_addr, dmem_be, in_ready, out_valid}
                    !== {1'b1, 1'b0, ea, eb, 1'b0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL load_%0d_req got req=%b we=%b addr=%h be=%b rdy=%b ov=%b want 1 0 %h %b 0 0",
                             i, dmem_req, dmem_we, dmem_addr, dmem_be, in_ready, out_valid, ea, eb);
                end
                dmem_gnt = (c == gd);
                step();
            end
            dmem_gnt = 1'b0;
            for (int c = 1; c <= rd; c++) begin
                n_cmp++;
                if ({dmem_req, in_ready, out_valid} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL load_%0d_wait got req=%b rdy=%b ov=%b want 0 0 0", i, dmem_req, in_ready,
                             out_valid);
                end
                dmem_rvalid = (c == rd);
                dmem_rdata  = (c == rd) ? w : $urandom;
                step();
            end
            dmem_rvalid = 1'b0;
            exp = expect_pkt(wb, ed, 1'b1);
            n_cmp++;
            if ({out_valid, in_ready, mem2wb_packet} !== {1'b1, 1'b1, exp}) begin
                n_fail++;
                $display("FAIL load_%0d_data got ov=%b rdy=%b pkt=%h want 1 1 %h", i, out_valid, in_ready,
                         mem2wb_packet, exp);
            end
        end
    endtask

    task automatic test_misalign();
        for (int i = 0; i < 6; i++) begin
            rv32_ex2mem_wb_packet_t wb;
            wb = rand_wb();
            mem_packet = '{read_enable: !MA_ST[i], write_enable: MA_ST[i], addr: MA_ADDR[i], data: $urandom};
            ex_control_packet = '{load_type: 3'(MA_TYPE[i]), store_type: 2'(MA_TYPE[i])};
            wb_packet = wb;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            n_cmp++;
            if ({out_valid, misalign_err, mem2wb_packet.wb_enable, mem2wb_packet.wb_pc, dmem_req, in_ready,
                 timeout_err} !== {1'b1, 1'b1, 1'b0, wb.wb_pc, 1'b0, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL misalign_%0d got ov=%b err=%b wbe=%b pc=%h req=%b rdy=%b want 1 1 0 %h 0 1", i,
                         out_valid, misalign_err, mem2wb_packet.wb_enable, mem2wb_packet.wb_pc, dmem_req,
                         in_ready, wb.wb_pc);
            end
            step();
            n_cmp++;
            if ({misalign_err, out_valid, dmem_req} !== 3'b000) begin
                n_fail++;
                $display("FAIL misalign_%0d_pulse got err=%b ov=%b req=%b want 0 0 0", i, misalign_err,
                         out_valid, dmem_req);
            end
        end
    endtask

    task automatic test_timeout();
        rv32_ex2mem_wb_packet_t wb;
        int cyc;
        bit early;
        wb = rand_wb();
        mem_packet = '{read_enable: 1'b1, write_enable: 1'b0, addr: 32'h5000, data: 32'd0};
        ex_control_packet = '{load_type: LD_W, store_type: ST_W};
        wb_packet = wb;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        cyc = 1;
        early = 1'b0;
        while (timeout_err !== 1'b1 && cyc < 200) begin
            if (out_valid !== 1'b0) early = 1'b1;
            step();
            cyc++;
        end
        n_cmp++;
        if (cyc != TO + 1 || early) begin
            n_fail++;
            $display("FAIL timeout_latency got %0d cycles (early ov=%b) want %0d", cyc, early, TO + 1);
        end
        n_cmp++;
        if ({out_valid, mem2wb_packet.wb_enable, mem2wb_packet.wb_pc, in_ready}
            !== {1'b1, 1'b0, wb.wb_pc, 1'b1}) begin
            n_fail++;
            $display("FAIL timeout_retire got ov=%b wbe=%b pc=%h rdy=%b want 1 0 %h 1", out_valid,
                     mem2wb_packet.wb_enable, mem2wb_packet.wb_pc, in_ready, wb.wb_pc);
        end
        step();
        dmem_rvalid = 1'b1;
        dmem_rdata  = $urandom;
        step();
        dmem_rvalid = 1'b0;
        n_cmp++;
        if ({timeout_err, out_valid, in_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL timeout_stray_rvalid got err=%b ov=%b rdy=%b want 0 0 1", timeout_err, out_valid,
                     in_ready);
        end
    endtask

    task automatic test_reset_mid();
        rv32_ex2mem_wb_packet_t wb;
        rv32_mem2wb_packet_t exp;
        wb = rand_wb();
        mem_packet = '{read_enable: 1'b1, write_enable: 1'b0, addr: 32'h6004, data: 32'd0};
        ex_control_packet = '{load_type: LD_W, store_type: ST_W};
        wb_packet = wb;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, out_valid,
             mem2wb_packet, misalign_err, timeout_err} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs got rdy=%b req=%b addr=%h be=%b ov=%b pkt=%h want all 0", in_ready,
                     dmem_req, dmem_addr, dmem_be, out_valid, mem2wb_packet);
        end
        step();
        rst = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = $urandom;
        step();
        dmem_rvalid = 1'b0;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL midreset_rvalid_ignored got ov=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        wb = rand_wb();
        wb.wb_data = 32'd5;
        wb.wb_addr = 5'd3;
        mem_packet = '{read_enable: 1'b0, write_enable: 1'b0, addr: 32'd0, data: 32'd0};
        wb_packet = wb;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        exp = expect_pkt(wb, 32'd5, 1'b1);
        n_cmp++;
        if ({out_valid, mem2wb_packet} !== {1'b1, exp}) begin
            n_fail++;
            $display("FAIL midreset_addi got ov=%b pkt=%h want 1 %h", out_valid, mem2wb_packet, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst               = 1'b1;
        in_valid          = 1'b0;
        mem_packet        = '0;
        ex_control_packet = '0;
        wb_packet         = '0;
        dmem_gnt          = 1'b0;
        dmem_rvalid       = 1'b0;
        dmem_rdata        = '0;
        #1;
        test_reset();
        test_alu();
        test_store();
        test_load();
        test_misalign();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
